// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a word FIFO; frames are start, data LSB first, optional parity, stop.
// Optional flow control: define UART_TX_CTS_EN to add i_cts_n and gate new frames on it.
//
// state  | meaning
// IDLE   | line high, waiting for a buffered word
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit (only when PARITY_ON)
// STOP   | stop bit(s); may chain straight into the next START
module uart_tx_fifo #(
    parameter int CLK_FRE     = 50,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_ON   = 0,
    parameter int PARITY_TYPE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                            i_clk_sys,
    input  logic                            i_rst,
    input  logic [DATA_WIDTH-1:0]           i_data_tx,
    input  logic                            i_data_valid,
`ifdef UART_TX_CTS_EN
    input  logic                            i_cts_n,
`endif
    output logic                            o_data_ready,
    output logic                            o_uart_tx,
    output logic                            o_busy,
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level
);

    localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [15:0]      CYC_LAST  = 16'(CYCLE - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [LVL_W-1:0] DEPTH_L   = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic                  r_ready;

    state_t                r_state;
    logic [15:0]           r_cnt;
    logic [3:0]            r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;
    logic                  r_tx;
    logic                  r_busy;

    state_t                w_state_next;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_tx_bit;
    logic                  w_bit_end;
    logic                  w_fifo_nempty;
    logic                  w_cts_ok;
    logic [LVL_W-1:0]      w_level_next;
    logic [DATA_WIDTH-1:0] w_head;

`ifdef UART_TX_CTS_EN
    assign w_cts_ok = ~i_cts_n;
`else
    assign w_cts_ok = 1'b1;
`endif

    assign w_push        = i_data_valid && r_ready;
    assign w_fifo_nempty = (r_level != '0);
    assign w_head        = r_mem[r_rd_ptr];
    assign w_bit_end     = (r_cnt == CYC_LAST);

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + LVL_W'(1);
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - LVL_W'(1);
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge i_clk_sys) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data_tx;
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level <= w_level_next;
            r_ready <= (w_level_next < DEPTH_L);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_tx_bit     = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_fifo_nempty && w_cts_ok) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_tx_bit = 1'b0;
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_bit = r_shift[0];
                if (w_bit_end && (r_bit_idx == DATA_LAST)) begin
                    w_state_next = (PARITY_ON != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                w_tx_bit = r_parity;
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                // Chaining into START here keeps consecutive frames gap-free.
                if (w_bit_end && (r_bit_idx == STOP_LAST)) begin
                    if (w_fifo_nempty && w_cts_ok) begin
                        w_pop        = 1'b1;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_bit;
            // Registered alongside the line so busy falls as the last stop bit ends.
            r_busy  <= (r_state != S_IDLE) || w_fifo_nempty;

            if ((r_state == S_IDLE) || w_bit_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (w_state_next != r_state) begin
                r_bit_idx <= '0;
            end else if (w_bit_end && ((r_state == S_DATA) || (r_state == S_STOP))) begin
                r_bit_idx <= r_bit_idx + 4'd1;
            end

            if (w_pop) begin
                r_shift  <= w_head;
                r_parity <= (^w_head) ^ (PARITY_TYPE != 0);
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
            end
        end
    end

    assign o_data_ready = r_ready;
    assign o_uart_tx    = r_tx;
    assign o_busy       = r_busy;
    assign o_fifo_level = r_level;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations (8N1, 9E1, 7O2) at 10 clocks per bit,
// a frame-level reference model, and per-DUT line monitors fed from expectation queues.
module tb_uart_tx_fifo;

    localparam int CYCLE = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] d0;
    logic [8:0] d1;
    logic [6:0] d2;
    logic       v0, v1, v2;
    logic       rdy0, rdy1, rdy2;
    logic       tx0, tx1, tx2;
    logic       bsy0, bsy1, bsy2;
    logic [2:0] lvl0, lvl1, lvl2;

    int checks = 0;
    int errors = 0;
    int epoch  = 0;
    int sent[3];
    int frames[3];
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];

    uart_tx_fifo #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_WIDTH(8), .PARITY_ON(0),
                   .PARITY_TYPE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
        .i_clk_sys(clk), .i_rst(rst), .i_data_tx(d0), .i_data_valid(v0),
        .o_data_ready(rdy0), .o_uart_tx(tx0), .o_busy(bsy0), .o_fifo_level(lvl0));

    uart_tx_fifo #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_WIDTH(9), .PARITY_ON(1),
                   .PARITY_TYPE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut1 (
        .i_clk_sys(clk), .i_rst(rst), .i_data_tx(d1), .i_data_valid(v1),
        .o_data_ready(rdy1), .o_uart_tx(tx1), .o_busy(bsy1), .o_fifo_level(lvl1));

    uart_tx_fifo #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_WIDTH(7), .PARITY_ON(1),
                   .PARITY_TYPE(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut2 (
        .i_clk_sys(clk), .i_rst(rst), .i_data_tx(d2), .i_data_valid(v2),
        .o_data_ready(rdy2), .o_uart_tx(tx2), .o_busy(bsy2), .o_fifo_level(lvl2));

    // Configuration of each instance, as the model sees it.
    function automatic int dw_of(input int id);
        return (id == 0) ? 8 : (id == 1) ? 9 : 7;
    endfunction
    function automatic int par_of(input int id);
        return (id == 0) ? 0 : 1;
    endfunction
    function automatic int odd_of(input int id);
        return (id == 2) ? 1 : 0;
    endfunction
    function automatic int stop_of(input int id);
        return (id == 2) ? 2 : 1;
    endfunction
    function automatic int nbits_of(input int id);
        return 1 + dw_of(id) + par_of(id) + stop_of(id);
    endfunction

    function automatic logic tx_of(input int id);
        return (id == 0) ? tx0 : (id == 1) ? tx1 : tx2;
    endfunction
    function automatic int rdy_of(input int id);
        return (id == 0) ? int'(rdy0) : (id == 1) ? int'(rdy1) : int'(rdy2);
    endfunction
    function automatic int busy_of(input int id);
        return (id == 0) ? int'(bsy0) : (id == 1) ? int'(bsy1) : int'(bsy2);
    endfunction
    function automatic int lvl_of(input int id);
        return (id == 0) ? int'(lvl0) : (id == 1) ? int'(lvl1) : int'(lvl2);
    endfunction

    function automatic logic [8:0] rnd_word(input int id);
        return 9'($urandom_range(0, (1 << dw_of(id)) - 1));
    endfunction

    // Line image of one frame, bit 0 first on the wire.
    function automatic logic [11:0] frame_vec(input int id, input logic [8:0] w);
        logic [11:0] v;
        int n;
        int ones;
        v    = '0;
        ones = 0;
        for (int i = 0; i < dw_of(id); i++) begin
            v[1 + i] = w[i];
            ones += int'(w[i]);
        end
        n = 1 + dw_of(id);
        if (par_of(id) != 0) begin
            v[n] = ((ones % 2) == 1) ^ (odd_of(id) != 0);
            n++;
        end
        for (int s = 0; s < stop_of(id); s++) begin
            v[n] = 1'b1;
            n++;
        end
        return v;
    endfunction

    task automatic check(input string name, input int id, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0d expected=%0d", name, id, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [8:0] w);
        if (id == 0) q0.push_back(w);
        else if (id == 1) q1.push_back(w);
        else q2.push_back(w);
    endtask

    task automatic pop_exp(input int id, output bit have, output logic [8:0] w);
        have = 1'b0;
        w    = '0;
        if (id == 0 && q0.size() > 0) begin have = 1'b1; w = q0.pop_front(); end
        if (id == 1 && q1.size() > 0) begin have = 1'b1; w = q1.pop_front(); end
        if (id == 2 && q2.size() > 0) begin have = 1'b1; w = q2.pop_front(); end
    endtask

    task automatic set_in(input int id, input logic [8:0] w, input logic v);
        if (id == 0) begin d0 = w[7:0]; v0 = v; end
        else if (id == 1) begin d1 = w; v1 = v; end
        else begin d2 = w[6:0]; v2 = v; end
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input int id, input logic [8:0] w, output int acc);
        bit took;
        int g;
        set_in(id, w, 1'b1);
        took = 1'b0;
        g    = 0;
        while (!took && g < 3000) begin
            took = (rdy_of(id) == 1);
            @(posedge clk);
            #1;
            g++;
        end
        set_in(id, w, 1'b0);
        acc = -1;
        if (!took) begin
            check("send_timeout", id, 0, 1);
        end else begin
            acc = cyc;
            push_exp(id, w);
            sent[id]++;
        end
    endtask

    task automatic wait_idle(input int id, input int limit, output int tdrop);
        int g;
        g     = 0;
        tdrop = -1;
        while (tdrop < 0 && g < limit) begin
            if (busy_of(id) == 0) tdrop = cyc;
            else begin @(posedge clk); #1; g++; end
        end
        if (tdrop < 0) check("idle_timeout", id, 0, 1);
    endtask

    task automatic monitor(input int id);
        logic [11:0] expv;
        logic [11:0] actv;
        logic [8:0]  w;
        int          nb;
        int          ep;
        bit          have;
        bit          bad;
        bit          abort;
        forever begin
            @(negedge clk);
            if (!rst && tx_of(id) == 1'b0) begin
                ep = epoch;
                nb = nbits_of(id);
                pop_exp(id, have, w);
                expv  = have ? frame_vec(id, w) : '1;
                actv  = '0;
                bad   = 1'b0;
                abort = 1'b0;
                for (int b = 0; b < nb && !abort; b++) begin
                    for (int s = 0; s < CYCLE && !abort; s++) begin
                        if (b != 0 || s != 0) begin
                            @(negedge clk);
                            if (epoch != ep || rst) abort = 1'b1;
                        end
                        if (!abort) begin
                            if (tx_of(id) !== expv[b]) bad = 1'b1;
                            if (s == CYCLE / 2) actv[b] = tx_of(id);
                        end
                    end
                end
                if (!abort) begin
                    checks++;
                    frames[id]++;
                    if (!have || bad) begin
                        errors++;
                        $display("FAIL frame dut%0d actual_bits=%b expected_bits=%b queued=%0d",
                                 id, actv, expv, have);
                    end
                end
            end
        end
    endtask

    task automatic single(input int id, input logic [8:0] w);
        int t0;
        int tl;
        int tb;
        int g;
        send(id, w, t0);
        tl = -1;
        g  = 0;
        while (tl < 0 && g < 50) begin
            if (tx_of(id) == 1'b0) tl = cyc;
            else begin @(posedge clk); #1; g++; end
        end
        check("start_latency", id, tl - t0, 2);
        wait_idle(id, 2000, tb);
        check("busy_drop", id, tb - t0, 2 + nbits_of(id) * CYCLE);
    endtask

    task automatic fill(input int id);
        int t[6];
        int tb;
        for (int i = 0; i < 6; i++) begin
            send(id, rnd_word(id), t[i]);
            if (i == 4) begin
                check("level_full", id, lvl_of(id), 4);
                check("ready_full", id, rdy_of(id), 0);
            end
        end
        check("accept5_time", id, t[4] - t[0], 4);
        check("accept6_time", id, t[5] - t[0], nbits_of(id) * CYCLE + 2);
        wait_idle(id, 10000, tb);
        check("burst_line_time", id, tb - t[0], 2 + 6 * nbits_of(id) * CYCLE);
    endtask

    task automatic rand_stream(input int id, input int n);
        int a;
        int gap;
        int tb;
        for (int i = 0; i < n; i++) begin
            send(id, rnd_word(id), a);
            gap = $urandom_range(0, 9);
            if (gap > 6) gap = $urandom_range(20, 250);
            repeat (gap) begin @(posedge clk); #1; end
        end
        wait_idle(id, 10000, tb);
    endtask

    task automatic push_n(input int id, input int n);
        int a;
        for (int i = 0; i < n; i++) send(id, rnd_word(id), a);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int base[3];
        bit low_seen[3];
        rst = 1'b1;
        d0 = '0; d1 = '0; d2 = '0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        for (int i = 0; i < 3; i++) begin sent[i] = 0; frames[i] = 0; end
        repeat (3) @(posedge clk);
        #1;
        for (int id = 0; id < 3; id++) begin
            check("rst_tx", id, int'(tx_of(id)), 1);
            check("rst_ready", id, rdy_of(id), 1);
            check("rst_busy", id, busy_of(id), 0);
            check("rst_level", id, lvl_of(id), 0);
        end
        rst = 1'b0;
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none
        @(posedge clk);
        #1;

        fork
            single(0, 9'h0A5);
            single(1, 9'h103);
            single(2, 9'h041);
        join
        fork
            single(0, 9'h003);
            single(1, 9'h003);
            single(2, 9'h003);
        join
        fork
            fill(0);
            fill(1);
            fill(2);
        join
        fork
            rand_stream(0, 20);
            rand_stream(1, 20);
            rand_stream(2, 20);
        join
        for (int id = 0; id < 3; id++) check("frames_vs_sent", id, frames[id], sent[id]);

        // Reset during the 35th line clock of a frame with three more words queued.
        start = cyc;
        fork
            push_n(0, 4);
            push_n(1, 4);
            push_n(2, 4);
        join
        while (cyc < start + 36) begin @(posedge clk); #1; end
        rst = 1'b1;
        epoch++;
        q0.delete();
        q1.delete();
        q2.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int id = 0; id < 3; id++) begin
            check("midrst_tx", id, int'(tx_of(id)), 1);
            check("midrst_level", id, lvl_of(id), 0);
            check("midrst_busy", id, busy_of(id), 0);
            check("midrst_ready", id, rdy_of(id), 1);
            base[id]     = frames[id];
            low_seen[id] = 1'b0;
        end
        repeat (400) begin
            @(posedge clk);
            #1;
            for (int id = 0; id < 3; id++) if (tx_of(id) == 1'b0) low_seen[id] = 1'b1;
        end
        for (int id = 0; id < 3; id++) begin
            check("post_rst_line_low", id, int'(low_seen[id]), 0);
            check("post_rst_frames", id, frames[id] - base[id], 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
